// File: rtl/anyedge_delay_checker.sv
// anyedge_delay_checker
// Watches flag_a for any edge. On the first detected edge flag_b must be 0,
// and DELAY clocks later flag_b must be 1. The verdict (pass / err_pre /
// err_post) is sticky until clear or rst. Every detected edge is counted,
// saturating at 255.
//
// Handshake: there is no valid/ready pair. A check starts on the first
// detected edge (busy rises), and the verdict is presented when done rises.
// The verdict stays stable while done is 1. clear is the only way to
// re-arm, apart from rst.
module anyedge_delay_checker #(
  parameter int unsigned DELAY = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       flag_a,
  input  logic       flag_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_pre,
  output logic       err_post,
  output logic [7:0] edge_count,
  // Debug view of the FSM: 0 = IDLE, 1 = WAIT, 2 = DONE
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             a_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             err_pre_q;
  logic             err_post_q;
  logic [7:0]       edge_cnt_q;

  logic             edge_d;
  logic             b_not_zero_d;
  logic             b_not_one_d;

  // Edge detect and flag_b qualification.
  // The 4-state compares make X or Z on flag_b count as an error.
  always_comb begin
    edge_d       = enable & (flag_a ^ a_q);
    b_not_zero_d = (flag_b !== 1'b0);
    b_not_one_d  = (flag_b !== 1'b1);
  end

  // Track flag_a every clock, independent of enable, clear and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 1'b0;
    end else begin
      a_q <= flag_a;
    end
  end

  // Check FSM with registered outputs and saturating edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_pre_q  <= 1'b0;
      err_post_q <= 1'b0;
      edge_cnt_q <= 8'd0;
    end else if (clear) begin
      // Edges in this cycle are discarded on purpose.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_pre_q  <= 1'b0;
      err_post_q <= 1'b0;
      edge_cnt_q <= 8'd0;
    end else begin
      if (edge_d && (edge_cnt_q != 8'hFF)) begin
        edge_cnt_q <= edge_cnt_q + 8'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (edge_d) begin
            err_pre_q <= b_not_zero_d;
            cnt_q     <= CNT_LOAD;
            busy_q    <= 1'b1;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Further edges here are only counted; they never restart the delay.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            err_post_q <= b_not_one_d;
            pass_q     <= ~(err_pre_q | b_not_one_d);
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Verdict holds until clear or rst.
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_pre    = err_pre_q;
  assign err_post   = err_post_q;
  assign edge_count = edge_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_anyedge_delay_checker.sv
// Bench for anyedge_delay_checker: directed scenarios plus randomized checks.
// Drivers change inputs on the falling clock edge; the monitor samples 1
// time unit after the rising edge.
module tb_anyedge_delay_checker;

  localparam int DELAY = 3;
  localparam int CNT_W = 8;
  // {err_pre, err_post, pass, edge_count[7:0], busy_cycles[7:0]}
  localparam int EW = 19;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       clear;
  logic       flag_a;
  logic       flag_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic       err_pre;
  logic       err_post;
  logic [7:0] edge_count;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  logic [EW-1:0] exp_q[$];

  anyedge_delay_checker #(
    .DELAY(DELAY),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .flag_a    (flag_a),
    .flag_b    (flag_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_pre   (err_pre),
    .err_post  (err_post),
    .edge_count(edge_count),
    .state_o   (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got time %0t, required finish before 200000", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_pass"}, {31'd0, pass}, 32'd0);
    check({name, "_err_pre"}, {31'd0, err_pre}, 32'd0);
    check({name, "_err_post"}, {31'd0, err_post}, 32'd0);
    check({name, "_edge_count"}, {24'd0, edge_count}, 32'd0);
    check({name, "_state"}, {30'd0, state_o}, 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_count = 0;
    check_idle("clear");
  endtask

  // Move flag_a to a level without producing a detected edge.
  task automatic set_a(input logic v);
    if (flag_a !== v) begin
      @(negedge clk);
      enable = 1'b0;
      flag_a = v;
      @(negedge clk);
      enable = 1'b1;
    end
  endtask

  // One complete check. tmode: 0 no extra toggles, 1 toggle flag_a on every
  // WAIT cycle, 2 random toggles. The verdict is derived from the rules:
  // flag_b must be 0 on the starting edge and 1 DELAY clocks later.
  task automatic run_check(input logic pre_b, input logic post_b, input int tmode);
    logic [7:0] tg;
    int n;
    logic ep, eo;
    int cnt;
    tg = (tmode == 0) ? 8'd0 : (tmode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    n = 0;
    for (int i = 0; i < DELAY; i++) if (tg[i]) n++;
    ep = (pre_b !== 1'b0);
    eo = (post_b !== 1'b1);
    cnt = model_count + 1 + n;
    if (cnt > 255) cnt = 255;
    model_count = cnt;
    exp_q.push_back({ep, eo, ~(ep | eo), 8'(cnt), 8'(DELAY)});
    @(negedge clk);
    flag_b = pre_b;
    flag_a = ~flag_a;
    for (int i = 1; i <= DELAY; i++) begin
      @(negedge clk);
      flag_b = (i == DELAY) ? post_b : 1'($urandom_range(0, 1));
      if (tg[i-1]) flag_a = ~flag_a;
    end
    @(negedge clk);
    flag_b = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int busy_len = 0;
  logic prev_done = 1'b0;
  logic [EW-1:0] exp_v;
  logic [EW-1:0] act_v;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_len = 0;
      prev_done = 1'b0;
    end else begin
      checks++;
      if (pass !== (done & ~(err_pre | err_post))) begin
        errors++;
        $display("FAIL pass_consistency: got pass=%b, required %b (done=%b)", pass,
                 done & ~(err_pre | err_post), done);
      end
      if (done === 1'b1 && prev_done !== 1'b1) begin
        act_v = {err_pre, err_post, pass, edge_count, 8'(busy_len)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got verdict %0h, required no done", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL verdict: got pre=%b post=%b pass=%b cnt=%0d busy=%0d, required pre=%b post=%b pass=%b cnt=%0d busy=%0d",
                     act_v[18], act_v[17], act_v[16], act_v[15:8], act_v[7:0],
                     exp_v[18], exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
          end
        end
      end
      busy_len = (busy === 1'b1) ? busy_len + 1 : 0;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b1;
    clear = 1'b0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Happy path
    run_check(1'b0, 1'b1, 0);
    do_clear();

    // Pre-check failure on a falling edge
    set_a(1'b1);
    run_check(1'b1, 1'b1, 0);
    do_clear();

    // Post-check failure with toggles during WAIT (no retrigger)
    run_check(1'b0, 1'b0, 1);
    do_clear();

    // X on flag_b at the post-check
    run_check(1'b0, 1'bx, 0);
    do_clear();

    // Randomized checks
    for (int k = 0; k < 20; k++) begin
      run_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
      do_clear();
    end

    // enable=0 ignores edges
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flag_a = ~flag_a;
    end
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("en0_edge_count", {24'd0, edge_count}, 32'd0);
    check("en0_busy", {31'd0, busy}, 32'd0);
    check("en0_state", {30'd0, state_o}, 32'd0);

    // Saturation: 300 back-to-back toggles, flag_b held 0
    flag_b = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'(DELAY + 1), 8'(DELAY)});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      flag_a = ~flag_a;
    end
    repeat (2) @(negedge clk);
    check("sat_edge_count", {24'd0, edge_count}, 32'd255);
    check("sat_done", {31'd0, done}, 32'd1);
    do_clear();

    // clear coincident with an edge
    @(negedge clk);
    clear = 1'b1;
    flag_a = ~flag_a;
    @(negedge clk);
    clear = 1'b0;
    check("clr_edge_count", {24'd0, edge_count}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("clr_edge_count2", {24'd0, edge_count}, 32'd0);
    check("clr_busy2", {31'd0, busy}, 32'd0);

    // New check after clear runs correctly
    run_check(1'b0, 1'b1, 0);
    do_clear();

    // Asynchronous rst in the middle of WAIT
    @(negedge clk);
    flag_b = 1'b0;
    flag_a = ~flag_a;
    @(negedge clk);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    check("rst_cnt_before", {24'd0, edge_count}, 32'd1);
    #2;
    rst = 1'b1;
    flag_a = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (DELAY + 2) @(negedge clk);
    check("rst_no_done", {31'd0, done}, 32'd0);
    check("rst_no_busy", {31'd0, busy}, 32'd0);

    // Recovery after reset
    run_check(1'b0, 1'b1, 2);
    do_clear();

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
